// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Program-counter and fetch-sequencing stage in front of the control unit.
// Holds the word-addressed PC and chooses the next PC from the control
// unit's jump/branch decode and the ALU Zero flag. A three-state sequencer
// (RUN / WAIT_IN / HALTED) stops the machine on Halt and stalls on In
// instructions until the operator presses the confirm button.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   ControlJump    J/JAL taken (beats any branch)
//   BEQ, BNE       branch-if-equal / branch-if-not-equal instruction
//   Halt           halt instruction (beats everything else)
//   In             input instruction (stalls until confirm)
//   Zero           ALU operands equal
//   BranchOffset   signed branch immediate, relative to PC+1
//   JumpAddr       jump field; only the low ADDR_W bits are used
//   InputButton    raw asynchronous operator button, active-high
//   PC             current instruction address
//   PCPlus1        PC+1 (combinational), also the JAL link value
//   Commit         current instruction may write registers/memory
//   WaitingInput   sequencer is stalled waiting for the operator
//   Halted         sequencer is halted; only reset leaves this state
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int RESET_PC = 0,
    parameter int OFF_W    = 16,
    parameter int JADDR_W  = 26
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ControlJump,
    input  logic               BEQ,
    input  logic               BNE,
    input  logic               Halt,
    input  logic               In,
    input  logic               Zero,
    input  logic [OFF_W-1:0]   BranchOffset,
    input  logic [JADDR_W-1:0] JumpAddr,
    input  logic               InputButton,
    output logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  PCPlus1,
    output logic               Commit,
    output logic               WaitingInput,
    output logic               Halted
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        HALTED  = 2'd2
    } seqState_t;

    // Branch arithmetic is done in the wider of the two widths so a short
    // offset is still sign-extended correctly before truncation to ADDR_W.
    localparam int EXT_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

    seqState_t         state;
    seqState_t         stateNext;
    logic [ADDR_W-1:0] pcNext;

    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              confirm;

    logic [EXT_W-1:0]  branchSum;
    logic [ADDR_W-1:0] branchTarget;
    logic [ADDR_W-1:0] jumpTarget;
    logic              branchTaken;
    logic              unusedBits;

    // ------------------------------------------------------------------
    // Next-PC arithmetic
    // ------------------------------------------------------------------
    assign PCPlus1      = PC + ADDR_W'(1);
    assign branchSum    = EXT_W'(PCPlus1) + EXT_W'($signed(BranchOffset));
    assign branchTarget = branchSum[ADDR_W-1:0];
    assign jumpTarget   = JumpAddr[ADDR_W-1:0];
    assign branchTaken  = (BEQ & Zero) | (BNE & ~Zero);

    // Upper jump-field bits and the carry-out of the branch add are
    // intentionally discarded (targets wrap within the address space).
    assign unusedBits   = ^{JumpAddr, branchSum};

    // ------------------------------------------------------------------
    // Button synchroniser and rising-edge detect. confirm is derived only
    // from flopped copies, so InputButton never reaches an output
    // combinationally.
    // ------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking (<=) assignments so
    // the three flops shift one stage per edge instead of collapsing into
    // a single flop as blocking assignments would.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= InputButton;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign confirm = sync2 & ~sync3;

    // ------------------------------------------------------------------
    // Sequencer state and PC registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
            PC    <= ADDR_W'(RESET_PC);
        end else begin
            state <= stateNext;
            PC    <= pcNext;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-PC / Commit decode
    // ------------------------------------------------------------------
    // NOTE: all outputs of this block get a default before the case so no
    // path leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext = state;
        pcNext    = PC;
        Commit    = 1'b0;

        case (state)
            RUN: begin
                // Halt outranks In; both stall the PC and suppress Commit.
                // A confirm pulse arriving here is simply not looked at.
                if (Halt) begin
                    stateNext = HALTED;
                end else if (In) begin
                    stateNext = WAIT_IN;
                end else begin
                    Commit = 1'b1;
                    if (ControlJump) begin
                        pcNext = jumpTarget;
                    end else if (branchTaken) begin
                        pcNext = branchTarget;
                    end else begin
                        pcNext = PCPlus1;
                    end
                end
            end

            WAIT_IN: begin
                // The confirm cycle is the one cycle in which the In
                // instruction writes the operator's value.
                if (confirm) begin
                    Commit    = 1'b1;
                    pcNext    = PCPlus1;
                    stateNext = RUN;
                end
            end

            HALTED: begin
                stateNext = HALTED;
            end

            default: begin
                stateNext = RUN;
            end
        endcase
    end

    assign WaitingInput = (state == WAIT_IN);
    assign Halted       = (state == HALTED);

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Self-checking bench for pc_fetch_sequencer: a table of next-PC vectors,
// hand-written sequences for the stall / halt / reset corner cases, and a
// randomized run compared against an arithmetic next-PC model.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int ADDR_W = 10;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        clock;
    logic        reset;
    logic        ControlJump;
    logic        BEQ;
    logic        BNE;
    logic        Halt;
    logic        In;
    logic        Zero;
    logic [15:0] BranchOffset;
    logic [25:0] JumpAddr;
    logic        InputButton;
    logic [9:0]  PC;
    logic [9:0]  PCPlus1;
    logic        Commit;
    logic        WaitingInput;
    logic        Halted;

    int nVectors;
    int nMiscompares;

    pc_fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .ControlJump  (ControlJump),
        .BEQ          (BEQ),
        .BNE          (BNE),
        .Halt         (Halt),
        .In           (In),
        .Zero         (Zero),
        .BranchOffset (BranchOffset),
        .JumpAddr     (JumpAddr),
        .InputButton  (InputButton),
        .PC           (PC),
        .PCPlus1      (PCPlus1),
        .Commit       (Commit),
        .WaitingInput (WaitingInput),
        .Halted       (Halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          startPc;
        logic        jump;
        logic        beq;
        logic        bne;
        logic        zero;
        logic [15:0] offset;
        logic [25:0] jaddr;
        int          expPc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        ControlJump  = 1'b0;
        BEQ          = 1'b0;
        BNE          = 1'b0;
        Halt         = 1'b0;
        In           = 1'b0;
        Zero         = 1'b0;
        BranchOffset = '0;
        JumpAddr     = '0;
    endtask

    // Load an arbitrary PC through a jump (machine must be in RUN).
    task automatic setPc(input int target);
        clearInputs();
        ControlJump = 1'b1;
        JumpAddr    = 26'(target);
        step();
        clearInputs();
    endtask

    initial begin
        int commitAt;
        int modelPc;
        int expPc;
        int sext;

        nVectors     = 0;
        nMiscompares = 0;
        clearInputs();
        InputButton  = 1'b0;
        reset        = 1'b1;

        // ---------------- reset state and free-running count ----------
        #3;
        check("reset.pc", PC, 0);
        check("reset.commit", Commit, 1);
        check("reset.waiting", WaitingInput, 0);
        check("reset.halted", Halted, 0);
        check("reset.pcplus1", PCPlus1, 1);
        @(posedge clock);
        #4 reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("count.pc%0d", k), PC, k);
            check($sformatf("count.commit%0d", k), Commit, 1);
        end

        // ---------------- table-driven next-PC vectors ----------------
        //             start  J  BEQ BNE Z  offset     jaddr         exp
        vecs.push_back('{7,    1, 1,  0,  1, 16'd0,     26'h3FF_FC12, 10'h012});
        vecs.push_back('{20,   0, 1,  0,  1, 16'hFFFB,  26'd0,        16});
        vecs.push_back('{20,   0, 1,  0,  0, 16'hFFFB,  26'd0,        21});
        vecs.push_back('{1023, 0, 0,  1,  0, 16'd2,     26'd0,        2});
        vecs.push_back('{50,   0, 0,  1,  1, 16'd9,     26'd0,        51});
        vecs.push_back('{60,   0, 1,  1,  0, 16'd4,     26'd0,        65});
        vecs.push_back('{60,   0, 1,  1,  1, 16'hFFFE,  26'd0,        59});
        vecs.push_back('{20,   0, 1,  0,  1, 16'h7FFF,  26'd0,        20});
        vecs.push_back('{100,  0, 0,  1,  0, 16'h8000,  26'd0,        101});
        vecs.push_back('{500,  1, 0,  1,  0, 16'd3,     26'h3FF,      1023});
        vecs.push_back('{1023, 0, 0,  0,  0, 16'd0,     26'd0,        0});
        vecs.push_back('{3,    0, 0,  0,  1, 16'd100,   26'd77,       4});

        foreach (vecs[i]) begin
            setPc(vecs[i].startPc);
            ControlJump  = vecs[i].jump;
            BEQ          = vecs[i].beq;
            BNE          = vecs[i].bne;
            Zero         = vecs[i].zero;
            BranchOffset = vecs[i].offset;
            JumpAddr     = vecs[i].jaddr;
            #2;
            check($sformatf("vec%0d.start", i), PC, vecs[i].startPc);
            check($sformatf("vec%0d.pcplus1", i), PCPlus1,
                  (vecs[i].startPc + 1) % DEPTH);
            check($sformatf("vec%0d.commit", i), Commit, 1);
            step();
            check($sformatf("vec%0d.next", i), PC, vecs[i].expPc);
        end
        clearInputs();

        // ---------------- In stall and operator confirm ---------------
        setPc(30);
        In = 1'b1;
        #2;
        check("in.commit_run", Commit, 0);
        step();
        check("in.waiting", WaitingInput, 1);
        for (int k = 0; k < 50; k++) begin
            step();
            check("in.hold_pc", PC, 30);
            check("in.hold_commit", Commit, 0);
            check("in.hold_waiting", WaitingInput, 1);
        end
        InputButton = 1'b1;
        commitAt    = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 3) InputButton = 1'b0;
            if (Commit && WaitingInput) begin
                commitAt = k;
                In       = 1'b0;
                break;
            end
        end
        InputButton = 1'b0;
        check("in.confirm_latency_ok", (commitAt >= 2 && commitAt <= 3), 1);
        In = 1'b0;
        step();
        check("in.resume_pc", PC, 31);
        check("in.resume_waiting", WaitingInput, 0);
        check("in.resume_commit", Commit, 1);
        // Second press while running: must not disturb sequencing.
        InputButton = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) InputButton = 1'b0;
            step();
            check("press_in_run.pc", PC, 31 + k);
            check("press_in_run.waiting", WaitingInput, 0);
            check("press_in_run.commit", Commit, 1);
        end
        InputButton = 1'b0;

        // ---------------- Halt beats In; async reset exits ------------
        setPc(40);
        Halt = 1'b1;
        In   = 1'b1;
        #2;
        check("halt.commit_run", Commit, 0);
        step();
        check("halt.halted", Halted, 1);
        check("halt.waiting", WaitingInput, 0);
        check("halt.pc", PC, 40);
        Halt        = 1'b0;
        In          = 1'b0;
        ControlJump = 1'b1;
        JumpAddr    = 26'd5;
        InputButton = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) InputButton = 1'b0;
            step();
            check("halt.hold_pc", PC, 40);
            check("halt.hold_halted", Halted, 1);
            check("halt.hold_commit", Commit, 0);
        end
        clearInputs();
        #3 reset = 1'b1;
        #1;
        check("halt.reset_pc", PC, 0);
        check("halt.reset_halted", Halted, 0);
        #1 reset = 1'b0;
        step();
        check("halt.after_reset_pc", PC, 1);

        // ------- reset in WAIT_IN with button held high ---------------
        setPc(30);
        In = 1'b1;
        step();
        check("rst_wait.waiting", WaitingInput, 1);
        #2;
        InputButton = 1'b1;
        reset       = 1'b1;
        #1;
        In = 1'b0;
        check("rst_wait.pc", PC, 0);
        check("rst_wait.waiting_cleared", WaitingInput, 0);
        step();
        step();
        check("rst_wait.pc_in_reset", PC, 0);
        #3 reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("rst_wait.run_pc", PC, k);
            check("rst_wait.run_waiting", WaitingInput, 0);
            check("rst_wait.run_commit", Commit, 1);
        end
        InputButton = 1'b0;

        // ---------------- randomized run against a model --------------
        reset = 1'b1;
        #2 reset = 1'b0;
        modelPc = 0;
        for (int n = 0; n < 300; n++) begin
            ControlJump  = ($urandom_range(0, 3) == 0);
            BEQ          = 1'($urandom);
            BNE          = 1'($urandom);
            Zero         = 1'($urandom);
            BranchOffset = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                                       : 16'($signed($urandom_range(0, 40)) - 20);
            JumpAddr     = 26'($urandom);
            #2;
            check("rand.pcplus1", PCPlus1, (modelPc + 1) % DEPTH);
            check("rand.commit", Commit, 1);
            sext = int'($signed(BranchOffset));
            if (ControlJump)
                expPc = int'(JumpAddr % 26'(DEPTH));
            else if ((BEQ && Zero) || (BNE && !Zero))
                expPc = ((modelPc + 1 + sext) % DEPTH + DEPTH) % DEPTH;
            else
                expPc = (modelPc + 1) % DEPTH;
            step();
            check("rand.pc", PC, expPc);
            modelPc = expPc;
        end
        clearInputs();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
